// File: rtl/fea_fixed_pkg.sv
// Fixed-point constants, FSM encoding and the saturation helper shared
// by the diffusion coefficient generator and its divider.
package fea_fixed_pkg;

   localparam int W     = 32;
   localparam int FRAC  = 16;
   localparam int N_DIV = W + FRAC;
   localparam int CNT_W = $clog2(N_DIV + 1);

   localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] HALF    =
      {{(W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

   localparam logic signed [2*W-1:0] SAT_MAX_X =
      {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] SAT_MIN_X =
      {{(W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   typedef struct packed {
      logic         sat;
      logic [W-1:0] val;
   } sat_t;

   function automatic sat_t saturate(input logic signed [2*W-1:0] v);
      sat_t r;
      r.sat = 1'b1;
      if (v > SAT_MAX_X) begin
         r.val = SAT_MAX;
      end else if (v < SAT_MIN_X) begin
         r.val = SAT_MIN;
      end else begin
         r.sat = 1'b0;
         r.val = v[W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/diffusion_coef_gen_if.sv
// Request/result bundle of the diffusion coefficient generator.
// master = requester/consumer side, slave = the generator.
interface diffusion_coef_gen_if;
   import fea_fixed_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] kval;
   logic [W-1:0] dt;
   logic [W-1:0] posx1;
   logic [W-1:0] posx2;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] coef;
   logic         div_zero;
   logic         sat;
   logic         unstable;

   modport master (
      output in_valid, kval, dt, posx1, posx2, out_ready,
      input  in_ready, out_valid, coef, div_zero, sat, unstable
   );

   modport slave (
      input  in_valid, kval, dt, posx1, posx2, out_ready,
      output in_ready, out_valid, coef, div_zero, sat, unstable
   );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// done pulses for one cycle after the last iteration.
module seq_divider
   import fea_fixed_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [W+FRAC-1:0] dividend,
   input  logic [W-1:0]      divisor,
   output logic              busy,
   output logic              done,
   output logic [W+FRAC-1:0] quotient,
   output logic              ovf
);

   localparam int QW = W + FRAC;

   logic [QW-1:0]    dq_q, dq_d;
   logic [W-1:0]     rem_q, rem_d;
   logic [W-1:0]     dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [W:0]       rem_sh;
   logic [W-1:0]     diff;
   logic             fits;

   // dq holds the unconsumed dividend bits on the left and the
   // quotient bits shifted in on the right.
   always_comb begin
      rem_sh = {rem_q, dq_q[QW-1]};
      diff   = rem_sh[W-1:0] - dvs_q;
      fits   = (rem_sh >= {1'b0, dvs_q});

      dq_d   = dq_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;

      if (start) begin
         dq_d   = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
         cnt_d  = CNT_W'(N_DIV);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = fits ? diff : rem_sh[W-1:0];
         dq_d  = {dq_q[QW-2:0], fits};
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dq_q   <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         dq_q   <= dq_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = dq_q;
   assign ovf      = |dq_q[QW-1:W-1];

endmodule

// File: rtl/diffusion_coef_gen.sv
// Explicit-scheme diffusion coefficient kval*dt/(posx1-posx2)^2 in
// signed fixed point, with divide-by-zero and instability flags.
module diffusion_coef_gen
   import fea_fixed_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   diffusion_coef_gen_if.slave bus
);

   state_t       state_q, state_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] coef_q, coef_d;
   logic         div_zero_q, div_zero_d;
   logic         sat_q, sat_d;
   logic         unstable_q, unstable_d;

   logic [W-1:0] kval_q, kval_d;
   logic [W-1:0] dt_q, dt_d;
   logic [W-1:0] posx1_q, posx1_d;
   logic [W-1:0] posx2_q, posx2_d;
   logic         neg_q, neg_d;
   logic         msat_q, msat_d;
   logic         dz_q, dz_d;

   logic signed [2*W-1:0] kval_x, dt_x, prod_kd, num_wide;
   sat_t                  num_s;
   logic                  num_neg;
   logic [W-1:0]          num_mag;
   logic [W:0]            dx, dx_neg;
   logic [W-1:0]          dx_mag;
   logic [2*W-1:0]        sq, sq_sh;
   logic                  den_sat;
   logic [W-1:0]          den;
   logic                  den_zero;
   logic [W+FRAC-1:0]     dividend;

   logic                  div_start;
   logic                  div_busy;
   logic                  div_done;
   logic                  div_ovf;
   logic [W+FRAC-1:0]     div_quot;

   logic [2*W-1:0]        q_ext, q_sgn;
   sat_t                  q_s;
   logic [W-1:0]          res_coef;
   logic                  res_sat;

   // dx is formed one bit wider so the subtraction never wraps; its
   // square is taken on the magnitude and cannot go negative.
   assign kval_x   = {{W{kval_q[W-1]}}, kval_q};
   assign dt_x     = {{W{dt_q[W-1]}}, dt_q};
   assign prod_kd  = kval_x * dt_x;
   assign num_wide = prod_kd >>> FRAC;
   assign num_s    = saturate(num_wide);
   assign num_neg  = num_s.val[W-1];
   assign num_mag  = num_neg ? (~num_s.val + 1'b1) : num_s.val;

   assign dx       = {posx1_q[W-1], posx1_q} - {posx2_q[W-1], posx2_q};
   assign dx_neg   = ~dx + 1'b1;
   assign dx_mag   = dx[W] ? dx_neg[W-1:0] : dx[W-1:0];
   assign sq       = {{W{1'b0}}, dx_mag} * {{W{1'b0}}, dx_mag};
   assign sq_sh    = sq >> FRAC;
   assign den_sat  = |sq_sh[2*W-1:W-1];
   assign den      = den_sat ? SAT_MAX : sq_sh[W-1:0];
   assign den_zero = (den == '0);
   assign dividend = {num_mag, {FRAC{1'b0}}};

   seq_divider u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (den),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quot),
      .ovf      (div_ovf)
   );

   always_comb begin
      q_ext = {{(W-FRAC){1'b0}}, div_quot};
      q_sgn = neg_q ? (~q_ext + 1'b1) : q_ext;
      q_s   = saturate(q_sgn);
      if (dz_q) begin
         res_coef = neg_q ? SAT_MIN : SAT_MAX;
         res_sat  = 1'b1;
      end else begin
         res_coef = q_s.val;
         res_sat  = msat_q | q_s.sat | div_ovf;
      end
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      coef_d      = coef_q;
      div_zero_d  = div_zero_q;
      sat_d       = sat_q;
      unstable_d  = unstable_q;
      kval_d      = kval_q;
      dt_d        = dt_q;
      posx1_d     = posx1_q;
      posx2_d     = posx2_q;
      neg_d       = neg_q;
      msat_d      = msat_q;
      dz_d        = dz_q;
      div_start   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               kval_d     = bus.kval;
               dt_d       = bus.dt;
               posx1_d    = bus.posx1;
               posx2_d    = bus.posx2;
               in_ready_d = 1'b0;
               state_d    = MUL;
            end
         end
         MUL: begin
            neg_d     = num_neg;
            msat_d    = num_s.sat | den_sat;
            dz_d      = den_zero;
            div_start = !den_zero && !div_busy;
            state_d   = DIV;
         end
         // A zero divisor skips the divider and resolves one cycle on.
         DIV: begin
            if (dz_q || div_done) begin
               coef_d      = res_coef;
               sat_d       = res_sat;
               div_zero_d  = dz_q;
               unstable_d  = ($signed(res_coef) > HALF);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         coef_q      <= '0;
         div_zero_q  <= 1'b0;
         sat_q       <= 1'b0;
         unstable_q  <= 1'b0;
         kval_q      <= '0;
         dt_q        <= '0;
         posx1_q     <= '0;
         posx2_q     <= '0;
         neg_q       <= 1'b0;
         msat_q      <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         coef_q      <= coef_d;
         div_zero_q  <= div_zero_d;
         sat_q       <= sat_d;
         unstable_q  <= unstable_d;
         kval_q      <= kval_d;
         dt_q        <= dt_d;
         posx1_q     <= posx1_d;
         posx2_q     <= posx2_d;
         neg_q       <= neg_d;
         msat_q      <= msat_d;
         dz_q        <= dz_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.coef      = coef_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.sat       = sat_q;
   assign bus.unstable  = unstable_q;

endmodule

// File: tb/tb_diffusion_coef_gen.sv
// Bench for diffusion_coef_gen: directed and random requests checked
// against an arithmetic reference of kval*dt/dx^2.
module tb_diffusion_coef_gen;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   typedef struct packed {
      logic [31:0] coef;
      logic        dz;
      logic        sat;
      logic        unst;
   } res_t;

   diffusion_coef_gen_if bus ();

   diffusion_coef_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input int k, input int d,
                                  input int a, input int b);
      res_t    r;
      longint  maxv, minv, p, num, dx, den, mag, q;
      longint unsigned ad, sq;
      maxv  = 64'sd2147483647;
      minv  = -64'sd2147483648;
      r     = '0;
      p     = longint'(k) * longint'(d);
      num   = p >>> 16;
      if (num > maxv) begin num = maxv; r.sat = 1'b1; end
      if (num < minv) begin num = minv; r.sat = 1'b1; end
      dx    = longint'(a) - longint'(b);
      ad    = (dx < 0) ? -dx : dx;
      sq    = ad * ad;
      den   = longint'(sq >> 16);
      if (den > maxv) begin den = maxv; r.sat = 1'b1; end
      if (den == 0) begin
         r.dz   = 1'b1;
         r.sat  = 1'b1;
         r.coef = (num < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         mag = (num < 0) ? -num : num;
         q   = (mag * 65536) / den;
         if (q > maxv) begin
            r.sat  = 1'b1;
            r.coef = (num < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         end else begin
            r.coef = 32'((num < 0) ? -q : q);
         end
      end
      r.unst = ($signed(r.coef) > 32768);
      return r;
   endfunction

   function automatic res_t obs();
      return {bus.coef, bus.div_zero, bus.sat, bus.unstable};
   endfunction

   function automatic int pick();
      int v;
      v = $urandom_range(0, 32'h80000);
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return v;
         2:       return -v;
         default: return $urandom_range(0, 32'h2000) - 32'h1000;
      endcase
   endfunction

   task automatic gen(output int k, output int d,
                      output int a, output int b);
      k = pick();
      d = pick();
      a = pick();
      case ($urandom_range(0, 2))
         0:       b = a - ($urandom_range(0, 600) - 300);
         1:       b = pick();
         default: b = a + $urandom_range(0, 32'h40000) - 32'h20000;
      endcase
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic send(input logic [31:0] k, input logic [31:0] d,
                       input logic [31:0] a, input logic [31:0] b);
      bus.kval     = k;
      bus.dt       = d;
      bus.posx1    = a;
      bus.posx2    = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.kval     = $urandom;
      bus.dt       = $urandom;
      bus.posx1    = $urandom;
      bus.posx2    = $urandom;
   endtask

   task automatic wait_out(output int lat, output bit to);
      lat = 0;
      to  = 1'b1;
      for (int i = 0; i < 120; i++) begin
         if (bus.out_valid) begin
            to = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.out_valid, obs()} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got=%h exp=0",
                  {bus.out_valid, obs()});
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got=%b exp=1", bus.in_ready);
      end
   endtask

   task automatic test_unit_coef();
      int   lat;
      bit   to;
      res_t exp;
      exp = {32'h0001_0000, 1'b0, 1'b0, 1'b1};
      send(32'h10000, 32'h4000, 32'h10000, 32'h8000);
      wait_out(lat, to);
      checks++;
      if (to || lat != 50) begin
         failures++;
         $display("FAIL unit_latency: got=%0d timeout=%0b exp=50", lat, to);
      end
      checks++;
      if (obs() !== exp) begin
         failures++;
         $display("FAIL unit_coef: got=%h exp=%h", obs(), exp);
      end
      take();
   endtask

   task automatic test_dx_sign();
      logic [31:0] xa [2] = '{32'h20000, 32'h10000};
      logic [31:0] xb [2] = '{32'h10000, 32'h20000};
      int   lat;
      bit   to;
      res_t exp;
      exp = {32'h0000_4000, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         send(32'h8000, 32'h8000, xa[i], xb[i]);
         wait_out(lat, to);
         checks++;
         if (to || obs() !== exp) begin
            failures++;
            $display("FAIL dx_sign[%0d]: got=%h timeout=%0b exp=%h",
                     i, obs(), to, exp);
         end
         take();
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] ks [3] = '{32'h10000, 32'hFFFF0000, 32'h10000};
      logic [31:0] xa [3] = '{32'h20000, 32'h20000, 32'h5};
      logic [31:0] xb [3] = '{32'h20000, 32'h20000, 32'h4};
      res_t ex [3] = '{{32'h7FFF_FFFF, 3'b111},
                       {32'h8000_0000, 3'b110},
                       {32'h7FFF_FFFF, 3'b111}};
      int   lat;
      bit   to;
      for (int i = 0; i < 3; i++) begin
         send(ks[i], 32'h10000, xa[i], xb[i]);
         wait_out(lat, to);
         checks++;
         if (to || lat != 2) begin
            failures++;
            $display("FAIL dz_latency[%0d]: got=%0d timeout=%0b exp=2",
                     i, lat, to);
         end
         checks++;
         if (obs() !== ex[i]) begin
            failures++;
            $display("FAIL dz_value[%0d]: got=%h exp=%h", i, obs(), ex[i]);
         end
         take();
      end
   endtask

   task automatic test_saturation();
      logic [31:0] ks [4] = '{32'hFFFE0000, 32'h640000,
                              32'h8000, 32'h8001};
      logic [31:0] ds [4] = '{32'h8000, 32'h640000,
                              32'h10000, 32'h10000};
      logic [31:0] xa [4] = '{32'h20000, 32'h100, 32'h10000, 32'h10000};
      res_t ex [4] = '{{32'hFFFF_C000, 3'b000},
                       {32'h7FFF_FFFF, 3'b011},
                       {32'h0000_8000, 3'b000},
                       {32'h0000_8001, 3'b001}};
      int   lat;
      bit   to;
      for (int i = 0; i < 4; i++) begin
         send(ks[i], ds[i], xa[i], 32'h0);
         wait_out(lat, to);
         checks++;
         if (to || lat != 50 || obs() !== ex[i]) begin
            failures++;
            $display("FAIL sat_case[%0d]: got=%h lat=%0d exp=%h lat=50",
                     i, obs(), lat, ex[i]);
         end
         take();
      end
   endtask

   task automatic test_hold();
      int   k, d, a, b, lat;
      bit   to;
      res_t exp;
      exp = model(32'h18000, 32'h2000, 32'h30000, 32'h10000);
      send(32'h18000, 32'h2000, 32'h30000, 32'h10000);
      wait_out(lat, to);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.kval  = $urandom;
         bus.dt    = $urandom;
         bus.posx1 = $urandom;
         bus.posx2 = $urandom;
         @(posedge clk);
         #1;
         checks++;
         if ({bus.out_valid, bus.in_ready, obs()} !== {2'b10, exp}) begin
            failures++;
            $display("FAIL hold[%0d]: got=%h exp=%h", i,
                     {bus.out_valid, bus.in_ready, obs()}, {2'b10, exp});
         end
      end
      bus.in_valid = 1'b0;
      take();
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL hold_release: got=%b exp=01",
                  {bus.out_valid, bus.in_ready});
      end
      gen(k, d, a, b);
      exp = model(k, d, a, b);
      send(k, d, a, b);
      wait_out(lat, to);
      checks++;
      if (to || obs() !== exp) begin
         failures++;
         $display("FAIL hold_next: got=%h timeout=%0b exp=%h", obs(), to, exp);
      end
      take();
   endtask

   task automatic test_back_to_back();
      int   k, d, a, b, lat;
      bit   to;
      res_t exp;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         gen(k, d, a, b);
         exp = model(k, d, a, b);
         send(k, d, a, b);
         wait_out(lat, to);
         checks++;
         if (to || lat != (exp.dz ? 2 : 50)) begin
            failures++;
            $display("FAIL b2b_latency[%0d]: got=%0d timeout=%0b exp=%0d",
                     n, lat, to, exp.dz ? 2 : 50);
         end
         checks++;
         if (obs() !== exp) begin
            failures++;
            $display("FAIL b2b_value[%0d] k=%h d=%h a=%h b=%h: got=%h exp=%h",
                     n, k, d, a, b, obs(), exp);
         end
         @(posedge clk);
         #1;
         checks++;
         if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_done_len[%0d]: got=%b exp=01",
                     n, {bus.out_valid, bus.in_ready});
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int   lat;
      bit   to;
      res_t exp;
      send(32'h10000, 32'h4000, 32'h10000, 32'h8000);
      wait_out(lat, to);
      take();
      send(32'h8000, 32'h8000, 32'h20000, 32'h10000);
      repeat (20) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, obs()} !== '0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got=%h exp=0",
                  {bus.out_valid, obs()});
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL mid_reset_idle: got=%b exp=01",
                  {bus.out_valid, bus.in_ready});
      end
      exp = model(32'hFFFE0000, 32'h8000, 32'h20000, 32'h0);
      send(32'hFFFE0000, 32'h8000, 32'h20000, 32'h0);
      wait_out(lat, to);
      checks++;
      if (to || lat != 50 || obs() !== exp) begin
         failures++;
         $display("FAIL mid_reset_fresh: got=%h lat=%0d exp=%h lat=50",
                  obs(), lat, exp);
      end
      take();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.kval      = '0;
      bus.dt        = '0;
      bus.posx1     = '0;
      bus.posx2     = '0;
      test_reset();
      test_unit_coef();
      test_dx_sign();
      test_div_zero();
      test_saturation();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
